// File: rtl/ready_tracker.sv
// Pointer and occupancy manager for one circular operand buffer.
// Tracks write/read pointers with round bits, the unread count, a wrapping
// per-slot ready mask, and sticky overflow/underflow flags.
module ready_tracker #(
  parameter int ADDR_W = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic                pop,
  input  logic [ADDR_W:0]     pop_cnt,
  input  logic                flush,
  output logic [ADDR_W-1:0]   w_addr,
  output logic [ADDR_W-1:0]   r_addr,
  output logic                w_round,
  output logic                r_round,
  output logic [ADDR_W:0]     count,
  output logic                full,
  output logic                empty,
  output logic [2**ADDR_W-1:0] ready,
  output logic                ovf,
  output logic                udf
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] w_addr_q, w_addr_d;
  logic [ADDR_W-1:0] r_addr_q, r_addr_d;
  logic              w_round_q, w_round_d;
  logic              r_round_q, r_round_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;

  logic              full_c;
  logic              push_acc;
  logic              pop_acc;
  logic [ADDR_W:0]   r_sum;
  logic [ADDR_W:0]   pop_amt;
  logic [ADDR_W:0]   push_amt;

  assign full_c = (count_q == DEPTH_C);

  // Next-state: acceptance from registered state only, flush over push/pop
  always_comb begin
    w_addr_d  = w_addr_q;
    r_addr_d  = r_addr_q;
    w_round_d = w_round_q;
    r_round_d = r_round_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    udf_d     = udf_q;

    push_acc  = push & ~full_c;
    pop_acc   = pop & (pop_cnt != '0) & (pop_cnt <= count_q);
    // r_addr < DEPTH and pop_cnt <= DEPTH, so the carry bit alone marks a wrap
    r_sum     = {1'b0, r_addr_q} + pop_cnt;
    pop_amt   = pop_acc ? pop_cnt : '0;
    push_amt  = {{ADDR_W{1'b0}}, push_acc};

    if (flush) begin
      r_addr_d  = w_addr_q;
      r_round_d = w_round_q;
      count_d   = '0;
      ovf_d     = 1'b0;
      udf_d     = 1'b0;
    end else begin
      if (push_acc) begin
        w_addr_d = w_addr_q + 1'b1;
        if (w_addr_q == '1) begin
          w_round_d = ~w_round_q;
        end
      end
      if (pop_acc) begin
        r_addr_d = r_sum[ADDR_W-1:0];
        if (r_sum[ADDR_W]) begin
          r_round_d = ~r_round_q;
        end
      end
      count_d = count_q + push_amt - pop_amt;
      if (push & full_c) begin
        ovf_d = 1'b1;
      end
      if (pop & (pop_cnt > count_q)) begin
        udf_d = 1'b1;
      end
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      w_addr_q  <= '0;
      r_addr_q  <= '0;
      w_round_q <= 1'b0;
      r_round_q <= 1'b0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      w_addr_q  <= w_addr_d;
      r_addr_q  <= r_addr_d;
      w_round_q <= w_round_d;
      r_round_q <= r_round_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
    end
  end

  // Ready mask: slot i holds unread data if its distance from r_addr is below count
  always_comb begin
    ready = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      ready[i] = ({1'b0, ADDR_W'(i) - r_addr_q} < count_q);
    end
  end

  assign w_addr  = w_addr_q;
  assign r_addr  = r_addr_q;
  assign w_round = w_round_q;
  assign r_round = r_round_q;
  assign count   = count_q;
  assign full    = full_c;
  assign empty   = (count_q == '0);
  assign ovf     = ovf_q;
  assign udf     = udf_q;

endmodule
